// File: rtl/write_controller_pkg.sv
// Shared types for the UART packet link: stream beat format, block
// destination addresses and the write-controller state encoding.
package write_controller_pkg;

  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
    logic       SoP;
    logic       EoP;
    logic       Valid;
  } UART_PACKET;

  localparam logic [7:0] READ_DESTINATION  = 8'h00;
  localparam logic [7:0] WRITE_DESTINATION = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    GET_DATA,
    WRITE,
    SEND_ACK,
    DISCARD
  } wr_state_e;

endpackage

// File: rtl/write_controller.sv
// Register-write endpoint of the UART packet link. Parses write packets
// (address byte + DATA_LENGTH data bytes), issues a one-cycle write strobe
// and optionally returns a one-byte acknowledge packet.
//
// state    | meaning
// IDLE     | waiting for a header addressed to this block
// GET_DATA | shifting in data bytes of an accepted header
// WRITE    | opWrEnable high for this single cycle
// SEND_ACK | ack beat held on opTxStream until ipTxReady
// DISCARD  | dropping the rest of a malformed packet up to EoP
module write_controller
  import write_controller_pkg::*;
#(
  parameter logic [7:0] WRITE_DESTINATION = 8'h01,
  parameter int         DATA_LENGTH       = 4,
  parameter bit         ACK_ENABLE        = 1'b1
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  UART_PACKET  ipRxStream,
  input  logic        ipTxReady,
  output UART_PACKET  opTxStream,
  output logic [7:0]  opWrAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  output logic [7:0]  opErrorCount,
  output logic        opBusy
);

  localparam logic [7:0] PKT_LENGTH = 8'(DATA_LENGTH + 1);
  localparam logic [7:0] LAST_IDX   = 8'(DATA_LENGTH - 1);

  wr_state_e   state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  reply_q, reply_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  err_q, err_d;
  logic [31:0] data_q, data_d;
  logic        wr_en_q, wr_en_d;
  UART_PACKET  tx_q, tx_d;

  logic        err_inc;
  logic        is_hdr;
  logic        hdr_ok;
  wr_state_e   hdr_state;

  // A header is any valid SoP beat for this block; its outcome depends only on Length/EoP.
  assign is_hdr    = ipRxStream.Valid && ipRxStream.SoP &&
                     (ipRxStream.Destination == WRITE_DESTINATION);
  assign hdr_ok    = (ipRxStream.Length == PKT_LENGTH);
  assign hdr_state = hdr_ok ? GET_DATA : (ipRxStream.EoP ? IDLE : DISCARD);

  // Next-state, byte assembly, ack formation and error accounting.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    reply_d = reply_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    tx_d    = tx_q;
    err_d   = err_q;
    err_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_hdr) begin
          state_d = hdr_state;
          err_inc = !hdr_ok;
          if (hdr_ok) begin
            addr_d  = ipRxStream.Data;
            reply_d = ipRxStream.Source;
            cnt_d   = 8'd0;
          end
        end
      end
      GET_DATA: begin
        if (ipRxStream.Valid) begin
          if (ipRxStream.SoP) begin
            // Unexpected start of packet: abandon the current one and
            // re-evaluate this beat as a fresh header.
            err_inc = 1'b1;
            state_d = is_hdr ? hdr_state : IDLE;
            if (is_hdr && hdr_ok) begin
              addr_d  = ipRxStream.Data;
              reply_d = ipRxStream.Source;
              cnt_d   = 8'd0;
            end
          end else begin
            data_d = {data_q[23:0], ipRxStream.Data};
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == LAST_IDX) begin
              if (ipRxStream.EoP) begin
                state_d = WRITE;
                wr_en_d = 1'b1;
              end else begin
                err_inc = 1'b1;
                state_d = DISCARD;
              end
            end else if (ipRxStream.EoP) begin
              err_inc = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      WRITE: begin
        err_inc = is_hdr;
        if (ACK_ENABLE) begin
          state_d          = SEND_ACK;
          tx_d.Source      = WRITE_DESTINATION;
          tx_d.Destination = reply_q;
          tx_d.Length      = 8'd1;
          tx_d.Data        = addr_q;
          tx_d.SoP         = 1'b1;
          tx_d.EoP         = 1'b1;
          tx_d.Valid       = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_ACK: begin
        err_inc = is_hdr;
        if (ipTxReady) begin
          tx_d    = '0;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (ipRxStream.Valid && ipRxStream.EoP) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // All controller state and registered outputs.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
      reply_q <= 8'd0;
      cnt_q   <= 8'd0;
      data_q  <= 32'd0;
      wr_en_q <= 1'b0;
      tx_q    <= '0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      reply_q <= reply_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
    end
  end

  assign opTxStream   = tx_q;
  assign opWrAddress  = addr_q;
  assign opWrData     = data_q;
  assign opWrEnable   = wr_en_q;
  assign opErrorCount = err_q;
  assign opBusy       = (state_q != IDLE);

endmodule

// File: tb/tb_write_controller.sv
// Scoreboard bench for write_controller: packet-level reference model
// pushes expected writes/acks/error totals, negedge monitors pop and compare.
module tb_write_controller;
  import write_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  UART_PACKET  rx;
  logic        tx_ready;
  UART_PACKET  tx;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [7:0]  err_cnt;
  logic        busy;

  always #5 clk = ~clk;

  write_controller #(
    .WRITE_DESTINATION(8'h01),
    .DATA_LENGTH      (4),
    .ACK_ENABLE       (1'b1)
  ) dut (
    .ipClk       (clk),
    .ipReset     (rst),
    .ipRxStream  (rx),
    .ipTxReady   (tx_ready),
    .opTxStream  (tx),
    .opWrAddress (wr_addr),
    .opWrData    (wr_data),
    .opWrEnable  (wr_en),
    .opErrorCount(err_cnt),
    .opBusy      (busy)
  );

  typedef struct {logic [7:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic [7:0] dest; logic [7:0] addr;} ack_t;

  wr_t        wr_q[$];
  ack_t       ack_q[$];
  wr_t        e_wr;
  ack_t       e_ack;
  int         errors = 0;
  int         checks = 0;
  int         exp_err = 0;
  bit         ready_forced = 1'b1;
  bit         ready_val = 1'b1;
  bit         in_ack = 1'b0;
  bit         acc_pending = 1'b0;
  UART_PACKET ack_cap;
  UART_PACKET last_rx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void bump_err();
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
  endfunction

  function automatic UART_PACKET mk(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                                    input logic [7:0] dt, input logic sop, input logic eop);
    UART_PACKET p;
    p.Source = s; p.Destination = d; p.Length = l; p.Data = dt;
    p.SoP = sop; p.EoP = eop; p.Valid = 1'b1;
    return p;
  endfunction

  function automatic logic [7:0] r8();
    return 8'($urandom);
  endfunction

  // Ready driver: random backpressure unless a directed test pins it.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = ready_forced ? ready_val : ($urandom_range(0, 9) < 7);
    end
  end

  // Beat actually sampled at each edge, for strobe-latency checking.
  always @(posedge clk) last_rx = rx;

  // Monitor: write strobes and ack beats against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_ack = 1'b0;
        acc_pending = 1'b0;
      end else begin
        if (wr_en) begin
          check("wr_latency_eop", 64'(last_rx.Valid && last_rx.EoP), 64'(1));
          if (wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected: got addr %0h data %0h, required no write", wr_addr, wr_data);
          end else begin
            e_wr = wr_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(e_wr.addr));
            check("wr_data", 64'(wr_data), 64'(e_wr.data));
          end
        end
        if (acc_pending) begin
          check("ack_valid_drop", 64'(tx.Valid), 64'(0));
          acc_pending = 1'b0;
          in_ack = 1'b0;
        end else if (tx.Valid) begin
          if (!in_ack) begin
            in_ack = 1'b1;
            ack_cap = tx;
            if (ack_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL ack_unexpected: got dest %0h data %0h, required no ack", tx.Destination, tx.Data);
            end else begin
              e_ack = ack_q.pop_front();
              check("ack_dest", 64'(tx.Destination), 64'(e_ack.dest));
              check("ack_src", 64'(tx.Source), 64'(8'h01));
              check("ack_data", 64'(tx.Data), 64'(e_ack.addr));
              check("ack_len_sop_eop", 64'({tx.Length, tx.SoP, tx.EoP}), 64'({8'd1, 1'b1, 1'b1}));
            end
          end else begin
            check("ack_stable", 64'(tx), 64'(ack_cap));
          end
          if (tx_ready) acc_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input UART_PACKET b);
    @(posedge clk); #1;
    rx = b;
  endtask

  task automatic idle_beat();
    logic [63:0] r;
    UART_PACKET p;
    r = {$urandom, $urandom};
    p = r[$bits(UART_PACKET)-1:0];
    p.Valid = 1'b0;
    drive(p);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) idle_beat();
  endtask

  task automatic data_beat(input logic [7:0] b, input logic eop);
    gap();
    drive(mk(r8(), r8(), r8(), b, 1'b0, eop));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    idle_beat();
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic pkt_good(input logic [7:0] src, input logic [7:0] addr, input logic [31:0] d);
    wr_q.push_back('{addr: addr, data: d});
    ack_q.push_back('{dest: src, addr: addr});
    gap();
    drive(mk(src, 8'h01, 8'd5, addr, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) data_beat(d[31-8*i -: 8], i == 3);
  endtask

  task automatic pkt_short(input int k);
    bump_err();
    drive(mk(r8(), 8'h01, 8'd5, r8(), 1'b1, 1'b0));
    for (int i = 1; i <= k; i++) data_beat(r8(), i == k);
  endtask

  task automatic pkt_long(input int m);
    bump_err();
    drive(mk(r8(), 8'h01, 8'd5, r8(), 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) data_beat(r8(), 1'b0);
    for (int i = 1; i <= m; i++) data_beat(r8(), i == m);
  endtask

  task automatic pkt_badlen(input logic [7:0] len, input int n);
    bump_err();
    drive(mk(r8(), 8'h01, len, r8(), 1'b1, n == 0));
    for (int i = 1; i <= n; i++) data_beat(r8(), i == n);
  endtask

  task automatic pkt_wrongdest(input logic [7:0] dest);
    drive(mk(r8(), dest, 8'd5, r8(), 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) begin
      drive(mk(r8(), r8(), r8(), r8(), 1'b0, i == 3));
      @(negedge clk);
      check("ignored_busy", 64'(busy), 64'(0));
    end
  endtask

  task automatic pkt_abandon(input int k);
    bump_err();
    drive(mk(r8(), 8'h01, 8'd5, r8(), 1'b1, 1'b0));
    for (int i = 0; i < k; i++) data_beat(r8(), 1'b0);
    pkt_good(r8(), r8(), $urandom);
  endtask

  task automatic check_err(input string name);
    check(name, 64'(err_cnt), 64'(exp_err));
  endtask

  logic [7:0] bl;
  logic [7:0] wd;
  int         nwait;

  initial begin
    rst = 1'b1;
    rx = '0;
    #2;
    check("rst_outputs", 64'({wr_en, wr_addr, wr_data, err_cnt, busy}), 64'(0));
    check("rst_tx", 64'(tx), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic write with immediate ready.
    ready_forced = 1'b1; ready_val = 1'b1;
    pkt_good(8'h05, 8'h10, 32'hDEADBEEF);
    wait_idle();
    check_err("err_after_good");

    // Ack backpressure, plus matching headers dropped in WRITE and SEND_ACK.
    ready_val = 1'b0;
    pkt_good(8'h05, 8'h10, 32'hDEADBEEF);
    drive(mk(8'h33, 8'h01, 8'd5, 8'h44, 1'b1, 1'b1));
    bump_err();
    idle_beat();
    nwait = 0;
    do begin @(negedge clk); nwait++; end while (!tx.Valid && nwait < 20);
    check("ack_seen", 64'(tx.Valid), 64'(1));
    drive(mk(8'h34, 8'h01, 8'd5, 8'h45, 1'b1, 1'b1));
    bump_err();
    idle_beat();
    @(negedge clk);
    check("ack_held_3", 64'(tx.Valid), 64'(1));
    ready_val = 1'b1;
    @(negedge clk);
    check("ack_held_4", 64'(tx.Valid), 64'(1));
    @(negedge clk);
    check("ack_dropped", 64'(tx.Valid), 64'(0));
    wait_idle();
    check_err("err_dropped_hdrs");

    // EoP on second data byte, then a normal write.
    pkt_short(2);
    wait_idle();
    check_err("err_short");
    pkt_good(8'h22, 8'h7A, 32'h01234567);
    wait_idle();

    // Wrong length then four further beats.
    pkt_badlen(8'd3, 4);
    wait_idle();
    check_err("err_badlen");

    // Read-controller destination is ignored.
    pkt_wrongdest(8'h00);
    wait_idle();
    check("ignored_busy_end", 64'(busy), 64'(0));
    check_err("err_wrongdest");

    // Randomized mix with random ack backpressure.
    ready_forced = 1'b0;
    for (int p = 0; p < 40; p++) begin
      case ($urandom_range(0, 5))
        0: pkt_good(r8(), r8(), $urandom);
        1: pkt_short($urandom_range(1, 3));
        2: pkt_long($urandom_range(1, 3));
        3: begin
          do bl = r8(); while (bl == 8'd5);
          pkt_badlen(bl, $urandom_range(0, 3));
        end
        4: begin
          do wd = r8(); while (wd == 8'h01);
          pkt_wrongdest(wd);
        end
        default: pkt_abandon($urandom_range(0, 3));
      endcase
      wait_idle();
      check_err("err_random");
    end
    ready_forced = 1'b1; ready_val = 1'b1;

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      drive(mk(r8(), 8'h01, 8'd2, r8(), 1'b1, 1'b1));
      bump_err();
    end
    wait_idle();
    check_err("err_saturate");

    // Asynchronous reset mid-packet.
    drive(mk(8'h09, 8'h01, 8'd5, 8'h5C, 1'b1, 1'b0));
    drive(mk(r8(), r8(), r8(), 8'hA5, 1'b0, 1'b0));
    drive(mk(r8(), r8(), r8(), 8'h3C, 1'b0, 1'b0));
    @(posedge clk); #3;
    rx = '0;
    rst = 1'b1;
    #1;
    check("midrst_outputs", 64'({wr_en, wr_addr, wr_data, err_cnt, busy}), 64'(0));
    check("midrst_tx", 64'(tx), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    pkt_good(8'h41, 8'hC3, 32'hCAFEF00D);
    wait_idle();
    check_err("err_after_reset");

    repeat (3) @(negedge clk);
    check("wr_q_empty", 64'(wr_q.size()), 64'(0));
    check("ack_q_empty", 64'(ack_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/write_controller.md
Name: write_controller

Overview:
Register-write endpoint of the UART packet link. It parses write packets from the packet-layer RX stream and issues a single-cycle 32-bit write to the register file. It then returns a one-byte acknowledge packet on the TX stream. It is the write-side counterpart of the read controller and sits between the UART packetiser and the register bank.

Parameters:
WRITE_DESTINATION, 8'h01, destination address that selects this block; also used as Source of the ack packet
DATA_LENGTH, 4, number of data bytes per write; the packet carries 1 address byte plus DATA_LENGTH data bytes
ACK_ENABLE, 1, 1 = send an ack packet after each successful write; 0 = no ack

Ports:
ipClk  input  1  system clock
ipReset  input  1  asynchronous, active-high reset
ipRxStream  input  UART_PACKET  incoming stream. Fields: Source[7:0], Destination[7:0], Length[7:0], Data[7:0], SoP, EoP, Valid. Valid qualifies one byte per cycle.
ipTxReady  input  1  downstream accepts the current TX beat when high
opTxStream  output  UART_PACKET  ack packet stream
opWrAddress  output  8  register address of the write
opWrData  output  32  write data, first received data byte in [31:24]
opWrEnable  output  1  one-cycle write strobe
opErrorCount  output  8  count of malformed packets, saturates at 8'hFF
opBusy  output  1  high whenever state != IDLE

Behaviour:
- Reset: asynchronous on ipReset high, all state cleared immediately.
  - Reset values: state=IDLE, opWrEnable=0, opWrAddress=0, opWrData=0, opErrorCount=0, all opTxStream fields 0.
  - Reset mid-packet or mid-ack: abandon the packet; no write strobe, no ack.
- RX has no backpressure. Beats with Valid=0 are ignored in every state.
- States: IDLE, GET_DATA, WRITE, SEND_ACK, DISCARD.
- IDLE:
  - A beat with Valid, SoP and Destination==WRITE_DESTINATION is a header. Other beats are ignored silently.
  - Header with Length==DATA_LENGTH+1: capture Data to opWrAddress and Source to an internal reply register; clear the byte counter; go to GET_DATA.
  - Header with Length wrong: error++. If EoP on the same beat, stay in IDLE; otherwise go to DISCARD.
- GET_DATA, on each valid beat:
  - Shift: opWrData <= {opWrData[23:0], Data}; counter++.
  - SoP on a beat: error++. Treat that beat as a new header under the IDLE rules, in the same cycle.
  - EoP before the DATA_LENGTH-th data byte: error++ -> IDLE, no write.
  - DATA_LENGTH-th byte with EoP -> WRITE.
  - DATA_LENGTH-th byte without EoP: error++ -> DISCARD.
- WRITE:
  - opWrEnable=1 for exactly this one cycle; address and data are stable.
  - Latency: strobe is high in the cycle after the EoP beat is sampled.
  - Next state: SEND_ACK if ACK_ENABLE, else IDLE.
- SEND_ACK:
  - opTxStream holds Valid=1, SoP=1, EoP=1, Length=1, Source=WRITE_DESTINATION, Destination=captured Source, Data=opWrAddress.
  - Fields are stable until a cycle where ipTxReady=1. Valid drops on the following cycle, then IDLE.
  - If ipTxReady is already high on entry, the ack is one cycle long.
- RX beats arriving in WRITE or SEND_ACK are dropped. A dropped beat with SoP and a matching destination counts error++.
- DISCARD: drop beats until a valid EoP beat, then IDLE.
- opErrorCount increments at most once per cycle and holds at 8'hFF.

Decomposition:
- Structures package: UART_PACKET (existing); constants READ_DESTINATION=8'h00 and WRITE_DESTINATION=8'h01; the write-controller state enum.
- No sub-module. Byte assembly and the FSM are small enough to stay in one module.

Test Plan:
- Write packet, Source=8'h05, Length=5, bytes 10 DE AD BE EF, ipTxReady=1 -> opWrEnable pulses once the cycle after EoP with opWrAddress=8'h10, opWrData=32'hDEADBEEF. Then a single ack beat: Dest=8'h05, Src=8'h01, Data=8'h10.
- Same packet with ipTxReady low for 3 cycles after the write -> ack fields held constant for 4 cycles, Valid drops the cycle after ipTxReady=1.
- EoP on the 2nd data byte -> no opWrEnable, no ack, opErrorCount=1. A following good packet writes normally.
- Header with Length=3, then 4 further beats -> discarded up to EoP, opErrorCount=1, no write.
- Packet with Destination=8'h00 -> fully ignored: no write, no error, opBusy stays 0.
- ipReset asserted asynchronously between clock edges after 2 data bytes -> outputs go to reset values immediately. The next full packet writes correctly with opErrorCount=0.
